// File: rtl/bocks_ioctl_pkg.sv
// Shared types for the ioctl download engine: FSM states, default geometry, word layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bocks_ioctl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // Default geometry of the loader as used by bocks_top.
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 27;
   localparam int DEF_NUM_CH = 4;
   localparam int BYTES      = DEF_DATA_W / 8;
   localparam int LANE_W     = $clog2(BYTES);

   // clog2 that never returns zero, so single-entry fields still get one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Word as delivered to the target memories at default geometry.
   typedef struct packed {
      logic [clog2_min1(DEF_NUM_CH)-1:0] ch;
      logic [DEF_ADDR_W-1:0]             addr;
      logic [DEF_DATA_W-1:0]             data;
      logic [BYTES-1:0]                  be;
   } ioctl_word_t;

endpackage

// File: rtl/bocks_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO with full/empty/count.
// Latency: push visible on pop_dat the cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module bocks_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rd_en   = pop & ~empty;
   assign wr_en   = push & (~full | rd_en);
   assign pop_dat = mem[rd_ptr];

   // Storage array, written only on an accepted push.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_dat;
   end

   // Pointers and occupancy; simultaneous push/pop leaves count unchanged.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bocks_ioctl_loader.sv
// Packs the ioctl byte stream into DATA_W words and routes them by latched ioctl_index.
// Latency: ioctl_wr to mem_valid 2 cycles when a word completes on that byte.
// Backpressure: ioctl_wait high when FIFO has <= 2 free entries or while flushing.
module bocks_ioctl_loader
   import bocks_ioctl_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 27,
   parameter int NUM_CH     = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                            clk_sys,
   input  logic                            reset_n,
   input  logic                            ioctl_download,
   input  logic                            ioctl_wr,
   input  logic [ADDR_W-1:0]               ioctl_addr,
   input  logic [7:0]                      ioctl_dout,
   input  logic [7:0]                      ioctl_index,
   output logic                            ioctl_wait,
   output logic                            mem_valid,
   input  logic                            mem_ready,
   output logic [clog2_min1(NUM_CH)-1:0]   mem_ch,
   output logic [ADDR_W-1:0]               mem_addr,
   output logic [DATA_W-1:0]               mem_data,
   output logic [DATA_W/8-1:0]             mem_be,
   output logic                            done,
   output logic [31:0]                     byte_count
);
   localparam int NBYTES  = DATA_W / 8;
   localparam int LANE_W1 = clog2_min1(NBYTES);
   localparam int CH_W    = clog2_min1(NUM_CH);
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam logic [LANE_W1-1:0] LANE_MASK  = LANE_W1'(NBYTES - 1);
   localparam logic [ADDR_W-1:0]  ALIGN_MASK = ~ADDR_W'(NBYTES - 1);

   typedef struct packed {
      logic [CH_W-1:0]   ch;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [NBYTES-1:0] be;
   } word_t;

   state_t              state, state_nx;
   logic                dl_q, pend_q;
   logic [7:0]          ch_q, eff_ch;
   logic                rise, go, acc, push, ch_ok, fresh;
   logic [LANE_W1-1:0]  lane;
   logic [LANE_W1+2:0]  off;
   logic [ADDR_W-1:0]   waddr;
   logic                pk_vld, pk_done;
   logic [ADDR_W-1:0]   pk_addr;
   logic [DATA_W-1:0]   pk_data, nxt_data;
   logic [NBYTES-1:0]   pk_be, nxt_be;
   word_t               push_word, pop_word;
   logic                fifo_full, fifo_empty;
   logic [CNT_W-1:0]    fifo_count;

   assign rise   = ioctl_download & ~dl_q;
   assign go     = (state == IDLE) & (rise | pend_q);
   // A byte may arrive on the very cycle the window opens, before ch_q is loaded.
   assign eff_ch = go ? ioctl_index : ch_q;
   assign ch_ok  = ({24'd0, eff_ch} < 32'(NUM_CH));
   assign acc    = ioctl_download & ioctl_wr & ((state == LOAD) | go);
   assign lane   = ioctl_addr[LANE_W1-1:0] & LANE_MASK;
   assign off    = {lane, 3'b000};
   assign waddr  = ioctl_addr & ALIGN_MASK;
   // Emit the held word when it is complete, a new word address shows up, or on flush.
   assign push   = pk_vld & (pk_done | (acc & (waddr != pk_addr)) | (state == FLUSH));

   assign push_word  = '{ch: eff_ch[CH_W-1:0], addr: pk_addr, data: pk_data, be: pk_be};
   assign mem_valid  = ~fifo_empty;
   assign mem_ch     = pop_word.ch;
   assign mem_addr   = pop_word.addr;
   assign mem_data   = pop_word.data;
   assign mem_be     = pop_word.be;
   assign ioctl_wait = (state == FLUSH) | fifo_full |
                       (fifo_count >= CNT_W'(FIFO_DEPTH - 2));

   // Merge the incoming byte into the held word, or start a fresh word if it is leaving.
   always_comb begin
      fresh    = push | ~pk_vld;
      nxt_data = fresh ? '0 : pk_data;
      nxt_be   = fresh ? '0 : pk_be;
      nxt_data[off +: 8] = ioctl_dout;
      nxt_be[lane]       = 1'b1;
   end

   // Packer register: one word under construction.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         pk_vld  <= 1'b0;
         pk_done <= 1'b0;
         pk_addr <= '0;
         pk_data <= '0;
         pk_be   <= '0;
      end else if (acc) begin
         pk_vld  <= 1'b1;
         pk_done <= (lane == LANE_MASK);
         pk_addr <= waddr;
         pk_data <= nxt_data;
         pk_be   <= nxt_be;
      end else if (push) begin
         pk_vld  <= 1'b0;
         pk_done <= 1'b0;
         pk_data <= '0;
         pk_be   <= '0;
      end
   end

   // Next-state logic for the download window.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (go) state_nx = LOAD;
         LOAD:    if (!ioctl_download) state_nx = FLUSH;
         FLUSH:   if (!pk_vld || push) state_nx = DRAIN;
         DRAIN:   if (fifo_empty) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State, edge detect, held-off start, channel latch, done pulse and byte counter.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state      <= IDLE;
         dl_q       <= 1'b0;
         pend_q     <= 1'b0;
         ch_q       <= '0;
         done       <= 1'b0;
         byte_count <= '0;
      end else begin
         state <= state_nx;
         dl_q  <= ioctl_download;
         done  <= (state == DRAIN) && fifo_empty;
         if (state == IDLE) pend_q <= 1'b0;
         else if (rise)     pend_q <= 1'b1;
         if (go) ch_q <= ioctl_index;
         if (go)       byte_count <= acc ? 32'd1 : 32'd0;
         else if (acc) byte_count <= byte_count + 32'd1;
      end
   end

   bocks_sync_fifo #(
      .WIDTH ($bits(word_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk_sys),
      .reset_n  (reset_n),
      .push     (push & ch_ok),
      .push_dat (push_word),
      .pop      (mem_valid & mem_ready),
      .pop_dat  (pop_word),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

endmodule

// File: tb/tb_bocks_ioctl_loader.sv
// Scoreboard bench for bocks_ioctl_loader at default geometry (32-bit words, 4 channels).
// Latency: n/a.
// Backpressure: drives mem_ready low for a stretch and obeys ioctl_wait.
module tb_bocks_ioctl_loader;

   typedef struct packed {
      logic [1:0]  ch;
      logic [26:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } exp_t;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        ioctl_download, ioctl_wr, ioctl_wait;
   logic [26:0] ioctl_addr;
   logic [7:0]  ioctl_dout, ioctl_index;
   logic        mem_valid, mem_ready, done;
   logic [1:0]  mem_ch;
   logic [26:0] mem_addr;
   logic [31:0] mem_data;
   logic [3:0]  mem_be;
   logic [31:0] byte_count;

   int   vectors = 0;
   int   miscompares = 0;
   int   done_cnt = 0;
   int   valid_cnt = 0;
   bit   wait_seen = 0;
   exp_t sb[$];

   // reference packer state
   logic        m_vld;
   logic [26:0] m_addr;
   logic [31:0] m_data;
   logic [3:0]  m_be;
   logic [7:0]  m_idx;

   // hold-stability snapshot
   bit          hold_vld = 0;
   exp_t        hold_word;

   always #5 clk_sys = ~clk_sys;

   bocks_ioctl_loader dut (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_index    (ioctl_index),
      .ioctl_wait     (ioctl_wait),
      .mem_valid      (mem_valid),
      .mem_ready      (mem_ready),
      .mem_ch         (mem_ch),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .mem_be         (mem_be),
      .done           (done),
      .byte_count     (byte_count)
   );

   // Output monitor: pops the scoreboard on each handshake and checks stalled outputs hold.
   always @(negedge clk_sys) begin
      exp_t cur, e;
      cur = {mem_ch, mem_addr, mem_data, mem_be};
      if (!reset_n) begin
         hold_vld = 0;
      end else begin
         if (done) done_cnt++;
         if (mem_valid) valid_cnt++;
         if (mem_valid && mem_ready) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL word_unexpected got %h want none", cur);
            end else begin
               e = sb.pop_front();
               if (cur !== e) begin
                  miscompares++;
                  $display("FAIL word got ch=%0d addr=%h data=%h be=%h want ch=%0d addr=%h data=%h be=%h",
                           mem_ch, mem_addr, mem_data, mem_be, e.ch, e.addr, e.data, e.be);
               end
            end
         end
         if (mem_valid && !mem_ready) begin
            if (hold_vld) begin
               vectors++;
               if (cur !== hold_word) begin
                  miscompares++;
                  $display("FAIL hold_stable got %h want %h", cur, hold_word);
               end
            end
            hold_vld  = 1;
            hold_word = cur;
         end else begin
            hold_vld = 0;
         end
      end
   end

   task automatic model_flush();
      if (m_vld && m_idx < 8'd4) sb.push_back('{m_idx[1:0], m_addr, m_data, m_be});
      m_vld = 0;
   endtask

   task automatic model_byte(input logic [26:0] a, input logic [7:0] d);
      logic [26:0] al;
      logic [1:0]  ln;
      al = a & ~27'd3;
      ln = a[1:0];
      if (m_vld && al != m_addr) model_flush();
      if (!m_vld) begin
         m_vld = 1; m_addr = al; m_data = '0; m_be = '0;
      end
      m_data[int'(ln)*8 +: 8] = d;
      m_be[ln] = 1'b1;
      if (ln == 2'd3) model_flush();
   endtask

   task automatic start_dl(input logic [7:0] idx);
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      m_idx = idx; m_vld = 0;
      @(posedge clk_sys); #1;
   endtask

   task automatic send_byte(input logic [26:0] a, input logic [7:0] d);
      int n = 0;
      while (ioctl_wait && n < 500) begin
         wait_seen = 1;
         @(posedge clk_sys); #1;
         n++;
      end
      if (ioctl_wait) begin
         vectors++; miscompares++;
         $display("FAIL wait_timeout got ioctl_wait=1 want 0 within 500 cycles");
      end
      ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
      model_byte(a, d);
      @(posedge clk_sys); #1;
      ioctl_wr = 1'b0;
   endtask

   task automatic finish_dl(output int pulses, output bit timed_out);
      int d0, n;
      d0 = done_cnt; n = 0;
      ioctl_download = 1'b0;
      model_flush();
      while (done_cnt == d0 && n < 400) begin
         @(posedge clk_sys); #1;
         n++;
      end
      timed_out = (done_cnt == d0);
      repeat (4) @(posedge clk_sys);
      #1;
      pulses = done_cnt - d0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; ioctl_download = 0; ioctl_wr = 0; ioctl_addr = '0;
      ioctl_dout = '0; ioctl_index = '0; mem_ready = 1'b1;
      repeat (2) @(posedge clk_sys);
      #1;
      vectors++; if (ioctl_wait !== 1'b0) begin miscompares++; $display("FAIL reset_wait got %b want 0", ioctl_wait); end
      vectors++; if (mem_valid !== 1'b0)  begin miscompares++; $display("FAIL reset_valid got %b want 0", mem_valid); end
      vectors++; if (done !== 1'b0)       begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
      vectors++; if (byte_count !== 32'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", byte_count); end
      reset_n = 1'b1;
      @(posedge clk_sys); #1;
   endtask

   task automatic test_sequential();
      int p; bit to;
      start_dl(8'd0);
      for (int i = 0; i < 8; i++) send_byte(27'(i), 8'(i));
      finish_dl(p, to);
      vectors++; if (to)            begin miscompares++; $display("FAIL seq_done_timeout got none want pulse"); end
      vectors++; if (p != 1)        begin miscompares++; $display("FAIL seq_done_pulses got %0d want 1", p); end
      vectors++; if (byte_count !== 32'd8) begin miscompares++; $display("FAIL seq_count got %0d want 8", byte_count); end
      vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL seq_left got %0d want 0", sb.size()); end
   endtask

   task automatic test_partial();
      int p; bit to;
      start_dl(8'd1);
      for (int i = 0; i < 5; i++) send_byte(27'(i), 8'hA0 + 8'(i));
      finish_dl(p, to);
      vectors++; if (to || p != 1)  begin miscompares++; $display("FAIL part_done got %0d want 1", p); end
      vectors++; if (byte_count !== 32'd5) begin miscompares++; $display("FAIL part_count got %0d want 5", byte_count); end
      vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL part_left got %0d want 0", sb.size()); end
   endtask

   task automatic test_jump();
      int p; bit to;
      start_dl(8'd2);
      send_byte(27'h10, 8'h11); send_byte(27'h11, 8'h22);
      send_byte(27'h40, 8'h33); send_byte(27'h41, 8'h44); send_byte(27'h42, 8'h55);
      finish_dl(p, to);
      vectors++; if (to || p != 1)  begin miscompares++; $display("FAIL jump_done got %0d want 1", p); end
      vectors++; if (byte_count !== 32'd5) begin miscompares++; $display("FAIL jump_count got %0d want 5", byte_count); end
      vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL jump_left got %0d want 0", sb.size()); end
   endtask

   task automatic test_backpressure();
      int p; bit to;
      wait_seen = 0;
      start_dl(8'd3);
      fork
         begin
            mem_ready = 1'b0;
            repeat (40) @(posedge clk_sys);
            #1 mem_ready = 1'b1;
         end
         begin
            for (int i = 0; i < 64; i++) send_byte(27'h100 + 27'(i), 8'($urandom_range(0, 255)));
         end
      join
      finish_dl(p, to);
      vectors++; if (!wait_seen)    begin miscompares++; $display("FAIL bp_wait got 0 want 1"); end
      vectors++; if (to || p != 1)  begin miscompares++; $display("FAIL bp_done got %0d want 1", p); end
      vectors++; if (byte_count !== 32'd64) begin miscompares++; $display("FAIL bp_count got %0d want 64", byte_count); end
      vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL bp_left got %0d want 0", sb.size()); end
   endtask

   task automatic test_bad_index();
      int p, v0; bit to;
      v0 = valid_cnt;
      start_dl(8'd7);
      for (int i = 0; i < 6; i++) send_byte(27'h20 + 27'(i), 8'h5A);
      finish_dl(p, to);
      vectors++; if (valid_cnt != v0) begin miscompares++; $display("FAIL bad_valid got %0d want 0", valid_cnt - v0); end
      vectors++; if (byte_count !== 32'd6) begin miscompares++; $display("FAIL bad_count got %0d want 6", byte_count); end
      vectors++; if (to || p != 1)  begin miscompares++; $display("FAIL bad_done got %0d want 1", p); end
   endtask

   task automatic test_reset_mid();
      start_dl(8'd1);
      mem_ready = 1'b0;
      for (int i = 0; i < 8; i++) send_byte(27'h200 + 27'(i), 8'(i) ^ 8'hC3);
      repeat (3) @(posedge clk_sys);
      #1;
      vectors++; if (mem_valid !== 1'b1) begin miscompares++; $display("FAIL mid_prefill got %b want 1", mem_valid); end
      reset_n = 1'b0; ioctl_download = 1'b0;
      @(posedge clk_sys); #1;
      vectors++; if (mem_valid !== 1'b0)  begin miscompares++; $display("FAIL mid_valid got %b want 0", mem_valid); end
      vectors++; if (ioctl_wait !== 1'b0) begin miscompares++; $display("FAIL mid_wait got %b want 0", ioctl_wait); end
      vectors++; if (byte_count !== 32'd0) begin miscompares++; $display("FAIL mid_count got %0d want 0", byte_count); end
      sb.delete(); m_vld = 0;
      reset_n = 1'b1; mem_ready = 1'b1;
      @(posedge clk_sys); #1;
      test_sequential();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_sequential();
      test_partial();
      test_jump();
      test_backpressure();
      test_bad_index();
      test_reset_mid();
      repeat (3) @(posedge clk_sys);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
